// File: rtl/pwm_axi_lite_slave.sv
// AXI4-Lite register block (CTRL/PERIOD/DUTY/PRESCALE) driving a prescaled
// PWM output. PERIOD and DUTY reach the counter through shadow copies that
// only reload at a counter wrap, so software writes never glitch the pin.
module pwm_axi_lite_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                              S_AXI_ACLK,
   input  logic                              S_AXI_ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   output logic                              pwm_out,
   output logic                              period_tick
);

   localparam int W = C_S_AXI_DATA_WIDTH;

   // AXI handshake state
   logic          awready_q, awready_d;
   logic          bvalid_q,  bvalid_d;
   logic          arready_q, arready_d;
   logic          rvalid_q,  rvalid_d;
   logic [W-1:0]  rdata_q,   rdata_d;

   // software-visible registers
   logic [W-1:0]  ctrl_q,     ctrl_d;
   logic [W-1:0]  period_q,   period_d;
   logic [W-1:0]  duty_q,     duty_d;
   logic [W-1:0]  prescale_q, prescale_d;

   // PWM engine state
   logic [W-1:0]  pre_q,        pre_d;
   logic [W-1:0]  cnt_q,        cnt_d;
   logic [W-1:0]  period_act_q, period_act_d;
   logic [W-1:0]  duty_act_q,   duty_act_d;
   logic          pwm_out_q,    pwm_out_d;
   logic          period_tick_q, period_tick_d;

   logic          enable;
   logic          pre_tick;
   logic          wrap;

   // protection bits and byte-offset address bits carry no meaning here
   logic unused;
   assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   function automatic logic [W-1:0] apply_strb(input logic [W-1:0]   old_val,
                                                input logic [W-1:0]   new_val,
                                                input logic [W/8-1:0] strb);
      logic [W-1:0] r;
      r = old_val;
      for (int b = 0; b < W/8; b++) begin
         if (strb[b]) r[b*8 +: 8] = new_val[b*8 +: 8];
      end
      return r;
   endfunction

   // AXI channel sequencing: accept, one-cycle ready pulse, then hold response
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
      awready_d = S_AXI_AWVALID && S_AXI_WVALID && !awready_q && !bvalid_q;
      bvalid_d  = bvalid_q;
      if (awready_q)                     bvalid_d = 1'b1;
      else if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;

      arready_d = S_AXI_ARVALID && !arready_q && !rvalid_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      if (arready_q) begin
         rvalid_d = 1'b1;
         case (S_AXI_ARADDR[3:2])
            2'd0:    rdata_d = ctrl_q;
            2'd1:    rdata_d = period_q;
            2'd2:    rdata_d = duty_q;
            default: rdata_d = prescale_q;
         endcase
      end else if (rvalid_q && S_AXI_RREADY) begin
         rvalid_d = 1'b0;
      end
   end

   // register file update during the address/data handshake cycle
   always_comb begin
      ctrl_d     = ctrl_q;
      period_d   = period_q;
      duty_d     = duty_q;
      prescale_d = prescale_q;
      if (awready_q) begin
         case (S_AXI_AWADDR[3:2])
            2'd0:    ctrl_d     = apply_strb(ctrl_q,     S_AXI_WDATA, S_AXI_WSTRB);
            2'd1:    period_d   = apply_strb(period_q,   S_AXI_WDATA, S_AXI_WSTRB);
            2'd2:    duty_d     = apply_strb(duty_q,     S_AXI_WDATA, S_AXI_WSTRB);
            default: prescale_d = apply_strb(prescale_q, S_AXI_WDATA, S_AXI_WSTRB);
         endcase
      end
   end

   // prescaler, main counter, shadow reload and registered output
   always_comb begin
      enable       = ctrl_q[0];
      pre_tick     = (pre_q >= prescale_q);
      wrap         = enable && pre_tick && (cnt_q >= period_act_q);
      pre_d        = pre_q;
      cnt_d        = cnt_q;
      period_act_d = period_act_q;
      duty_act_d   = duty_act_q;
      if (!enable) begin
         pre_d        = '0;
         cnt_d        = '0;
         period_act_d = period_q;
         duty_act_d   = duty_q;
      end else if (pre_tick) begin
         pre_d = '0;
         if (wrap) begin
            cnt_d        = '0;
            period_act_d = period_q;
            duty_act_d   = duty_q;
         end else begin
            cnt_d = cnt_q + W'(1);
         end
      end else begin
         pre_d = pre_q + W'(1);
      end
      pwm_out_d     = ctrl_q[1] ^ (enable && (cnt_q < duty_act_q));
      period_tick_d = wrap;
   end

   // all state flops with asynchronous active-high reset
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         awready_q     <= 1'b0;
         bvalid_q      <= 1'b0;
         arready_q     <= 1'b0;
         rvalid_q      <= 1'b0;
         rdata_q       <= '0;
         // NOTE: the register file is reset (not left uninitialised like a RAM) because software expects 0 after reset.
         ctrl_q        <= '0;
         period_q      <= '0;
         duty_q        <= '0;
         prescale_q    <= '0;
         pre_q         <= '0;
         cnt_q         <= '0;
         period_act_q  <= '0;
         duty_act_q    <= '0;
         pwm_out_q     <= 1'b0;
         period_tick_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
         awready_q     <= awready_d;
         bvalid_q      <= bvalid_d;
         arready_q     <= arready_d;
         rvalid_q      <= rvalid_d;
         rdata_q       <= rdata_d;
         ctrl_q        <= ctrl_d;
         period_q      <= period_d;
         duty_q        <= duty_d;
         prescale_q    <= prescale_d;
         pre_q         <= pre_d;
         cnt_q         <= cnt_d;
         period_act_q  <= period_act_d;
         duty_act_q    <= duty_act_d;
         pwm_out_q     <= pwm_out_d;
         period_tick_q <= period_tick_d;
      end
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = awready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = 2'b00;
   assign pwm_out       = pwm_out_q;
   assign period_tick   = period_tick_q;

endmodule

// File: tb/tb_pwm_axi_lite_slave.sv
// Bench for pwm_axi_lite_slave: AXI responses and PWM period windows are
// queued as expectations by the stimulus and compared by monitor processes.
module tb_pwm_axi_lite_slave;

   logic        aclk;
   logic        areset;
   logic [3:0]  awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [3:0]  araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic        pwm_out;
   logic        period_tick;

   pwm_axi_lite_slave dut (
      .S_AXI_ACLK   (aclk),
      .S_AXI_ARESET (areset),
      .S_AXI_AWADDR (awaddr),
      .S_AXI_AWPROT (awprot),
      .S_AXI_AWVALID(awvalid),
      .S_AXI_AWREADY(awready),
      .S_AXI_WDATA  (wdata),
      .S_AXI_WSTRB  (wstrb),
      .S_AXI_WVALID (wvalid),
      .S_AXI_WREADY (wready),
      .S_AXI_BRESP  (bresp),
      .S_AXI_BVALID (bvalid),
      .S_AXI_BREADY (bready),
      .S_AXI_ARADDR (araddr),
      .S_AXI_ARPROT (arprot),
      .S_AXI_ARVALID(arvalid),
      .S_AXI_ARREADY(arready),
      .S_AXI_RDATA  (rdata),
      .S_AXI_RRESP  (rresp),
      .S_AXI_RVALID (rvalid),
      .S_AXI_RREADY (rready),
      .pwm_out      (pwm_out),
      .period_tick  (period_tick)
   );

   typedef struct {
      int hi;
      int len;
   } win_t;

   int          checks;
   int          failures;
   logic [1:0]  b_q[$];
   logic [31:0] r_q[$];
   win_t        pwm_q[$];
   int          pwm_skip;

   logic [3:0]  map_addr [4];
   logic [31:0] map_val  [4];

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic fail_to(input string name);
      checks++;
      failures++;
      $display("FAIL %s: expected event did not occur within its cycle budget", name);
   endtask

   // B and R channel monitor: pops the expected response at each handshake
   initial begin
      logic [1:0]  eb;
      logic [31:0] er;
      forever begin
         @(negedge aclk);
         if (bvalid && bready) begin
            if (b_q.size() == 0) fail_to("b_unexpected");
            else begin
               eb = b_q.pop_front();
               check("bresp", {30'd0, bresp}, {30'd0, eb});
            end
         end
         if (rvalid && rready) begin
            if (r_q.size() == 0) fail_to("r_unexpected");
            else begin
               er = r_q.pop_front();
               check("rdata", rdata, er);
               check("rresp", {30'd0, rresp}, 32'd0);
            end
         end
      end
   end

   // PWM monitor: measures high time, length and edge count between period_tick pulses
   initial begin
      int   hi, len, edges;
      logic prev;
      win_t w;
      hi = 0; len = 0; edges = 0; prev = 1'b0;
      forever begin
         @(negedge aclk);
         if (areset) begin
            hi = 0; len = 0; edges = 0; prev = 1'b0;
         end else begin
            if (pwm_out !== prev) edges++;
            prev = pwm_out;
            if (pwm_out) hi++;
            len++;
            if (period_tick) begin
               if (pwm_skip > 0) pwm_skip--;
               else if (pwm_q.size() > 0) begin
                  w = pwm_q.pop_front();
                  check("pwm_high", hi, w.hi);
                  check("pwm_period", len, w.len);
                  check("pwm_edges_le2", {31'd0, edges <= 2}, 32'd1);
               end
               hi = 0; len = 0; edges = 0;
            end
         end
      end
   end

   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
      bit ok;
      ok = 1'b0;
      awaddr  = addr;
      wdata   = data;
      wstrb   = strb;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      b_q.push_back(2'b00);
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge aclk);
         if (awready && wready) ok = 1'b1;
      end
      if (ok) begin
         @(posedge aclk); #1;
      end else fail_to("aw_accept");
      awvalid = 1'b0;
      wvalid  = 1'b0;
   endtask

   task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp);
      bit ok;
      ok = 1'b0;
      araddr  = addr;
      arvalid = 1'b1;
      r_q.push_back(exp);
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge aclk);
         if (arready) ok = 1'b1;
      end
      if (ok) begin
         @(posedge aclk); #1;
      end else fail_to("ar_accept");
      arvalid = 1'b0;
   endtask

   task automatic drain_axi(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge aclk); #1;
         if (b_q.size() == 0 && r_q.size() == 0) ok = 1'b1;
      end
      if (!ok) begin
         fail_to(name);
         b_q.delete();
         r_q.delete();
      end
      @(posedge aclk); #1;
   endtask

   task automatic wait_pwm_drain(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge aclk); #1;
         if (pwm_q.size() == 0) ok = 1'b1;
      end
      if (!ok) begin
         fail_to(name);
         pwm_q.delete();
      end
      @(posedge aclk); #1;
   endtask

   // align to a few cycles after a wrap so a write lands well inside a period
   task automatic sync_mid(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge aclk);
         if (period_tick) ok = 1'b1;
      end
      if (!ok) fail_to(name);
      repeat (3) @(posedge aclk);
      #1;
   endtask

   task automatic wait_bvalid(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge aclk);
         if (bvalid) ok = 1'b1;
      end
      if (!ok) fail_to(name);
   endtask

   task automatic push_win(input int hi, input int len, input int n);
      win_t w;
      w.hi  = hi;
      w.len = len;
      for (int i = 0; i < n; i++) pwm_q.push_back(w);
   endtask

   initial begin
      int hi_cnt, tick_cnt;
      checks   = 0;
      failures = 0;
      pwm_skip = 0;
      map_addr = '{4'h0, 4'h4, 4'h8, 4'hC};
      map_val  = '{32'h0101FFFF, 32'habcd0001, 32'hdead0011, 32'hbeef0011};
      areset  = 1'b1;
      awaddr  = '0; awprot = '0; awvalid = 1'b0;
      wdata   = '0; wstrb  = '0; wvalid  = 1'b0;
      bready  = 1'b1;
      araddr  = '0; arprot = '0; arvalid = 1'b0;
      rready  = 1'b1;
      repeat (3) @(posedge aclk);
      #1 areset = 1'b0;

      // reset state
      @(negedge aclk);
      check("rst_awready", {31'd0, awready}, 32'd0);
      check("rst_wready",  {31'd0, wready},  32'd0);
      check("rst_bvalid",  {31'd0, bvalid},  32'd0);
      check("rst_arready", {31'd0, arready}, 32'd0);
      check("rst_rvalid",  {31'd0, rvalid},  32'd0);
      check("rst_rdata",   rdata,            32'd0);
      check("rst_bresp",   {30'd0, bresp},   32'd0);
      check("rst_rresp",   {30'd0, rresp},   32'd0);
      check("rst_pwm_out", {31'd0, pwm_out}, 32'd0);
      check("rst_tick",    {31'd0, period_tick}, 32'd0);
      @(posedge aclk); #1;

      // write-then-read of every register
      for (int k = 0; k < 4; k++) begin
         axi_write(map_addr[k], map_val[k], 4'hF);
         axi_read(map_addr[k], map_val[k]);
      end
      drain_axi("drain_map");

      // partial byte strobes
      axi_write(4'h4, 32'hFFFFFFFF, 4'hF);
      axi_write(4'h4, 32'h12345678, 4'b0101);
      axi_read(4'h4, 32'hFF34FF78);
      drain_axi("drain_strb");

      // basic PWM: PERIOD=9 DUTY=3 PRESCALE=0 -> 3 high / 10 clocks
      axi_write(4'h0, 32'd0, 4'hF);
      axi_write(4'h4, 32'd9, 4'hF);
      axi_write(4'h8, 32'd3, 4'hF);
      axi_write(4'hC, 32'd0, 4'hF);
      drain_axi("drain_cfg");
      pwm_skip = 1;
      push_win(3, 10, 2);
      axi_write(4'h0, 32'd1, 4'hF);
      wait_pwm_drain("pwm_basic");

      // DUTY=7 mid-period: current period stays 3 high, then 7
      sync_mid("sync_shadow");
      push_win(3, 10, 1);
      push_win(7, 10, 2);
      axi_write(4'h8, 32'd7, 4'hF);
      wait_pwm_drain("pwm_shadow");

      // DUTY=0 -> constant inactive
      sync_mid("sync_d0");
      axi_write(4'h8, 32'd0, 4'hF);
      pwm_skip = 1;
      push_win(0, 10, 2);
      wait_pwm_drain("pwm_duty0");

      // DUTY=20 > PERIOD -> constant active
      sync_mid("sync_d20");
      axi_write(4'h8, 32'd20, 4'hF);
      pwm_skip = 1;
      push_win(10, 10, 2);
      wait_pwm_drain("pwm_duty20");

      // DUTY=3 back, then PRESCALE=1 doubles every step
      sync_mid("sync_d3");
      axi_write(4'h8, 32'd3, 4'hF);
      pwm_skip = 1;
      push_win(3, 10, 1);
      wait_pwm_drain("pwm_duty3");
      sync_mid("sync_ps1");
      axi_write(4'hC, 32'd1, 4'hF);
      pwm_skip = 1;
      push_win(6, 20, 1);
      wait_pwm_drain("pwm_prescale1");
      sync_mid("sync_ps0");
      axi_write(4'hC, 32'd0, 4'hF);
      pwm_skip = 1;
      push_win(3, 10, 1);
      wait_pwm_drain("pwm_prescale0");

      // invert while enabled -> 3 low / 7 high
      sync_mid("sync_inv");
      axi_write(4'h0, 32'd3, 4'hF);
      pwm_skip = 1;
      push_win(7, 10, 2);
      wait_pwm_drain("pwm_invert");

      // invert while disabled -> constant 1, no ticks
      axi_write(4'h0, 32'd2, 4'hF);
      drain_axi("drain_dis");
      repeat (2) @(posedge aclk);
      hi_cnt = 0; tick_cnt = 0;
      repeat (12) begin
         @(negedge aclk);
         if (pwm_out) hi_cnt++;
         if (period_tick) tick_cnt++;
      end
      check("dis_inv_high", hi_cnt, 12);
      check("dis_ticks", tick_cnt, 0);
      @(posedge aclk); #1;

      // BREADY held low: second write waits, concurrent read proceeds
      bready = 1'b0;
      axi_write(4'h8, 32'h11112222, 4'hF);
      wait_bvalid("bvalid_first");
      @(posedge aclk); #1;
      fork
         axi_write(4'hC, 32'h33334444, 4'hF);
         axi_read(4'h8, 32'h11112222);
         begin : hold_b
            int bad_aw, bad_b;
            bad_aw = 0; bad_b = 0;
            repeat (5) begin
               @(negedge aclk);
               if (awready) bad_aw++;
               if (!bvalid) bad_b++;
            end
            #1;
            check("bvalid_held", bad_b, 0);
            check("aw_blocked", bad_aw, 0);
            check("read_independent", r_q.size(), 0);
            @(posedge aclk); #1;
            bready = 1'b1;
         end
      join
      drain_axi("drain_bp");
      axi_read(4'hC, 32'h33334444);
      drain_axi("drain_bp_rd");

      // asynchronous reset while a write response is pending
      bready = 1'b0;
      axi_write(4'h4, 32'h00005555, 4'hF);
      wait_bvalid("bvalid_rst");
      check("pwm_before_rst", {31'd0, pwm_out}, 32'd1);
      #3 areset = 1'b1;
      #1;
      check("async_rst_bvalid",  {31'd0, bvalid},  32'd0);
      check("async_rst_pwm",     {31'd0, pwm_out}, 32'd0);
      check("async_rst_awready", {31'd0, awready}, 32'd0);
      b_q.delete();
      @(posedge aclk); #1;
      areset = 1'b0;
      bready = 1'b1;
      @(posedge aclk); #1;
      axi_read(4'h4, 32'd0);
      axi_read(4'h0, 32'd0);
      drain_axi("drain_post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
